// File: rtl/alu_md_pkg.sv
// Shared op-code and FSM state encodings for the alu_md block and its
// iterative multiply/divide datapath.
package alu_md_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SRL   = 4'd4,
    OP_SRA   = 4'd5,
    OP_SLL   = 4'd6,
    OP_XOR   = 4'd7,
    OP_MULTU = 4'd8,
    OP_MULT  = 4'd9,
    OP_DIVU  = 4'd10,
    OP_DIV   = 4'd11,
    OP_MTHI  = 4'd12,
    OP_MTLO  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 8..11 (4'b10xx) run through the iterative datapath.
  function automatic logic is_md_op(input logic [3:0] code);
    return code[3] && !code[2];
  endfunction

endpackage

// File: rtl/md_iter.sv
// Radix-2 iterative multiply (shift-add) and divide (restoring) on operand
// magnitudes; sign correction is folded into the final-cycle outputs.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             divz_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] araw_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic [2*WIDTH-1:0] prod;

  assign mag_a = (is_signed && A[WIDTH-1]) ? (-A) : A;
  assign mag_b = (is_signed && B[WIDTH-1]) ? (-B) : B;
  assign done  = run_q && (cnt_q == CW'(WIDTH - 1));

  // One iteration step: acc holds the partial product / remainder,
  // mq holds the multiplier / dividend-becoming-quotient.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, opb_q & {WIDTH{mq_q[0]}}};
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    acc_nx  = sum[WIDTH:1];
    mq_nx   = {sum[0], mq_q[WIDTH-1:1]};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        mq_nx  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        mq_nx  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final outputs are only meaningful while done is high.
  always_comb begin
    prod = {acc_nx, mq_nx};
    if (neg_lo_q) prod = -prod;
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
    if (div_q) begin
      lo = neg_lo_q ? (-mq_nx) : mq_nx;
      hi = neg_hi_q ? (-acc_nx) : acc_nx;
      if (divz_q) begin
        lo = '1;
        hi = araw_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      divz_q   <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      araw_q   <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      div_q    <= is_div;
      neg_lo_q <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_hi_q <= is_signed && is_div && A[WIDTH-1];
      divz_q   <= is_div && (B == '0);
      acc_q    <= '0;
      mq_q     <= mag_a;
      opb_q    <= mag_b;
      araw_q   <= A;
    end else if (run_q) begin
      acc_q <= acc_nx;
      mq_q  <= mq_nx;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md.sv
// Single-cycle ALU plus hi/lo multiply/divide unit; ops 0-7 complete in one
// cycle, ops 8-11 run WIDTH iteration cycles in md_iter.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  state_e           state_d;
  op_e              op_d;
  logic             accept;
  logic             md_go;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  function automatic logic [WIDTH-1:0] alu_calc(input op_e f,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] r;
    sh = b[SHW-1:0];
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLL:  r = a << sh;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op_d   = op_e'(op);
  assign busy   = (state_q == ST_CALC);
  assign accept = start && !busy;
  assign md_go  = accept && is_md_op(op);

  md_iter #(
    .WIDTH(WIDTH)
  ) u_md_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (md_go),
    .is_signed(op[0]),
    .is_div   (op[1]),
    .A        (A),
    .B        (B),
    .done     (iter_done),
    .hi       (iter_hi),
    .lo       (iter_lo)
  );

  // DONE also accepts a new iterative op so back-to-back issue costs no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_go) state_d = ST_CALC;
      ST_CALC: if (iter_done) state_d = ST_DONE;
      ST_DONE: state_d = md_go ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid   <= 1'b0;
      result  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      valid   <= 1'b0;
      if (iter_done) begin
        hi    <= iter_hi;
        lo    <= iter_lo;
        valid <= 1'b1;
      end
      if (accept && !is_md_op(op)) begin
        valid <= 1'b1;
        case (op_d)
          OP_MTHI:          hi     <= A;
          OP_MTLO:          lo     <= A;
          OP_RSV14, OP_RSV15: result <= '0;
          default:          result <= alu_calc(op_d, A, B);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md at WIDTH=32: directed vectors push expected
// completions; a negedge monitor pops and compares on every valid pulse.
module tb_alu_md;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_md #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .valid (valid),
    .result(result),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           due;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no completion", cyc);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL %s_latency: got cycle %0d expected cycle %0d", e.name, cyc, e.due);
        end
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  // Drive one request; it is sampled at the next rising edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input int lat, input string name);
    exp_t e;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name = name;
      e.due  = cyc + lat;
      e.res  = m_res;
      e.hi   = m_hi;
      e.lo   = m_lo;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_res, input string name);
    m_res = exp_res;
    issue(o, a, b, 1'b1, 0, name);
  endtask

  task automatic mt(input bit to_hi, input logic [W-1:0] a, input string name);
    if (to_hi) m_hi = a;
    else       m_lo = a;
    issue(to_hi ? 4'd12 : 4'd13, a, '0, 1'b1, 0, name);
  endtask

  // Returns in the DONE cycle so the caller can issue back-to-back.
  task automatic md(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    ph   = m_hi;
    pl   = m_lo;
    m_hi = exp_hi;
    m_lo = exp_lo;
    issue(o, a, b, 1'b1, W, name);
    chk({name, "_busy_first"}, W'(busy), 1);
    repeat (W - 1) @(posedge clk);
    #1;
    chk({name, "_busy_last"}, W'(busy), 1);
    chk({name, "_hold_hi"}, hi, ph);
    chk({name, "_hold_lo"}, lo, pl);
    @(posedge clk);
    #1;
    chk({name, "_busy_done"}, W'(busy), 0);
  endtask

  initial begin
    op = 4'd0;
    start = 1'b1;
    A = 32'h1;
    B = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("reset_busy", W'(busy), 0);
    chk("reset_valid", W'(valid), 0);
    chk("reset_result", result, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b0;
    idle(1);

    alu(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add_wrap");
    alu(4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, "sub_wrap");
    alu(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, "and");
    alu(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, "or");
    alu(4'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, "xor");
    alu(4'd4, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl");
    alu(4'd5, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra");
    alu(4'd6, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, "sll");
    alu(4'd14, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, "rsv14");
    alu(4'd0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, "add");
    mt(1'b1, 32'h0000_CAFE, "mthi");
    idle(2);

    md(4'd9, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    idle(1);
    md(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    md(4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    md(4'd10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_zero");
    md(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    md(4'd11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
    md(4'd11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_s");
    alu(4'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, "add_in_done");
    idle(1);

    // ADD arriving while MULTU is busy must be dropped.
    m_hi = 32'h0;
    m_lo = 32'h0000_002A;
    issue(4'd8, 32'h0000_0006, 32'h0000_0007, 1'b1, W, "multu_busy");
    repeat (4) @(posedge clk);
    #1;
    issue(4'd0, 32'h0000_0100, 32'h0000_0200, 1'b0, 0, "");
    repeat (W - 5) @(posedge clk);
    #1;
    chk("multu_busy_done", W'(busy), 0);
    idle(2);

    // Reset in the middle of a DIVU aborts it silently.
    issue(4'd10, 32'h0000_0064, 32'h0000_0007, 1'b0, 0, "");
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_res = '0;
    m_hi  = '0;
    m_lo  = '0;
    chk("abort_busy", W'(busy), 0);
    chk("abort_valid", W'(valid), 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    idle(W + 5);
    alu(4'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, "add_after_reset");

    mt(1'b0, 32'h0000_1234, "mtlo");
    md(4'd10, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, "divu_b2b");
    idle(3);

    chk("scoreboard_empty", W'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
